// File: rtl/fast_conf_parser_if.sv
// Port bundle for fast_conf_parser.
// master = flit source / TCM side, slave = the parser.
interface fast_conf_parser_if #(
  parameter int ADDR_W = 12
);
  logic              data_in_valid;
  logic [133:0]      data_in;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rden;
  logic [31:0]       mem_rdata;
  logic              sel;
  logic              pkt_out_valid;
  logic [133:0]      pkt_out;
  logic              resp_valid;
  logic [133:0]      resp_data;
  logic [15:0]       err_cnt;

  modport master (
    output data_in_valid, data_in, mem_rdata,
    input  mem_wren, mem_addr, mem_wdata, mem_rden, sel,
    input  pkt_out_valid, pkt_out, resp_valid, resp_data, err_cnt
  );

  modport slave (
    input  data_in_valid, data_in, mem_rdata,
    output mem_wren, mem_addr, mem_wdata, mem_rden, sel,
    output pkt_out_valid, pkt_out, resp_valid, resp_data, err_cnt
  );
endinterface

// File: rtl/fast_conf_parser.sv
// Decodes FAST control/data packets: TCM writes/reads, sel bit, data forwarding.
// Strobes and forwarded flits are registered, 1 cycle after acceptance; no backpressure.
module fast_conf_parser #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  fast_conf_parser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR1, TYPE, SEL, WR, RD, FWD, DROP} pstate_t;
  typedef enum logic [1:0] {R_IDLE, R_HEAD, R_BODY, R_TAIL} rstate_t;

  pstate_t           pstate;
  rstate_t           rstate;
  logic              arg_seen;
  logic              resp_pend;
  logic              rd_cap;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] rd_addr;

  logic [1:0]  tag;
  logic [15:0] type_f;
  logic        is_head, is_tail, tail_rd, resp_start;
  logic [15:0] err_inc;

  assign tag     = bus.data_in[133:132];
  assign type_f  = bus.data_in[31:16];
  assign is_head = bus.data_in_valid && (tag == 2'b01);
  assign is_tail = bus.data_in_valid && (tag == 2'b10);
  assign err_inc = (bus.err_cnt == 16'hFFFF) ? bus.err_cnt : bus.err_cnt + 16'd1;

  // A tail after flit 3 starts the response at once; a flit-3 tail waits one cycle for read data.
  assign tail_rd    = is_tail && (pstate == RD) && arg_seen;
  assign resp_start = tail_rd || resp_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate            <= IDLE;
      arg_seen          <= 1'b0;
      resp_pend         <= 1'b0;
      rd_addr           <= '0;
      bus.sel           <= 1'b0;
      bus.err_cnt       <= 16'd0;
      bus.mem_wren      <= 1'b0;
      bus.mem_rden      <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= 32'd0;
      bus.pkt_out_valid <= 1'b0;
      bus.pkt_out       <= '0;
    end else begin
      bus.mem_wren      <= 1'b0;
      bus.mem_rden      <= 1'b0;
      bus.pkt_out_valid <= 1'b0;
      resp_pend         <= 1'b0;
      if (bus.data_in_valid) begin
        if (is_head && pstate != IDLE) begin
          pstate      <= HDR1;
          arg_seen    <= 1'b0;
          bus.err_cnt <= err_inc;
        end else begin
          case (pstate)
            IDLE: if (is_head) begin
              if (type_f == 16'h9010) begin
                pstate            <= FWD;
                bus.pkt_out_valid <= 1'b1;
                bus.pkt_out       <= bus.data_in;
              end else begin
                pstate <= HDR1;
              end
            end
            HDR1: begin
              pstate <= is_tail ? IDLE : TYPE;
              if (is_tail) bus.err_cnt <= err_inc;
            end
            TYPE: begin
              arg_seen <= 1'b0;
              if (is_tail) begin
                pstate      <= IDLE;
                bus.err_cnt <= err_inc;
              end else begin
                case (type_f)
                  16'h9001: pstate <= SEL;
                  16'h9003: pstate <= WR;
                  16'h9004: pstate <= RD;
                  default: begin
                    pstate      <= DROP;
                    bus.err_cnt <= err_inc;
                  end
                endcase
              end
            end
            SEL: begin
              if (!arg_seen) begin
                bus.sel  <= bus.data_in[16];
                arg_seen <= 1'b1;
              end
              if (is_tail) pstate <= IDLE;
            end
            WR: begin
              bus.mem_wren  <= 1'b1;
              bus.mem_addr  <= bus.data_in[16 +: ADDR_W];
              bus.mem_wdata <= bus.data_in[79:48];
              if (is_tail) pstate <= IDLE;
            end
            RD: begin
              if (!arg_seen) begin
                bus.mem_rden <= 1'b1;
                bus.mem_addr <= bus.data_in[16 +: ADDR_W];
                rd_addr      <= bus.data_in[16 +: ADDR_W];
                arg_seen     <= 1'b1;
                resp_pend    <= is_tail;
              end
              if (is_tail) pstate <= IDLE;
            end
            FWD: begin
              bus.pkt_out_valid <= 1'b1;
              bus.pkt_out       <= bus.data_in;
              if (is_tail) pstate <= IDLE;
            end
            DROP: if (is_tail) pstate <= IDLE;
            default: pstate <= IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate         <= R_IDLE;
      rd_cap         <= 1'b0;
      rdata_q        <= 32'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
    end else begin
      rd_cap <= bus.mem_rden;
      if (rd_cap) rdata_q <= bus.mem_rdata;
      case (rstate)
        R_IDLE: if (resp_start) begin
          rstate         <= R_HEAD;
          bus.resp_valid <= 1'b1;
          bus.resp_data  <= {2'b01, 4'h0, 128'd0};
        end
        R_HEAD: begin
          rstate        <= R_BODY;
          bus.resp_data <= {2'b11, 4'h0, 96'd0, 16'h9005, 16'd0};
        end
        R_BODY: begin
          rstate        <= R_TAIL;
          bus.resp_data <= {2'b10, 4'hF, 48'd0, rdata_q, 32'(rd_addr), 16'd0};
        end
        R_TAIL: begin
          rstate         <= R_IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_conf_parser.sv
// Directed bench for fast_conf_parser with hand-computed expectations.
module tb_fast_conf_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fast_conf_parser_if #(.ADDR_W(12)) bus();
  fast_conf_parser #(.ADDR_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int both = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TCM model: data valid exactly one cycle after the read strobe
  always @(posedge clk) bus.mem_rdata <= bus.mem_rden ? 32'h1234_5678 : 32'h0;

  logic [43:0]  wr_q[$];
  int           wr_t[$];
  logic [11:0]  rd_q[$];
  int           rd_t[$];
  logic [133:0] pk_q[$];
  int           pk_t[$];
  logic [133:0] rs_q[$];
  int           rs_t[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wren) begin wr_q.push_back({bus.mem_addr, bus.mem_wdata}); wr_t.push_back(cyc); end
      if (bus.mem_rden) begin rd_q.push_back(bus.mem_addr); rd_t.push_back(cyc); end
      if (bus.pkt_out_valid) begin pk_q.push_back(bus.pkt_out); pk_t.push_back(cyc); end
      if (bus.resp_valid) begin rs_q.push_back(bus.resp_data); rs_t.push_back(cyc); end
      if (bus.mem_wren && bus.mem_rden) both++;
    end
  end

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] tg, input logic [127:0] pl, output int t);
    bus.data_in_valid = 1'b1;
    bus.data_in = {tg, 4'hF, pl};
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    t = cyc;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ctrl_hdr(input logic [15:0] ty);
    int t;
    send(2'b01, 128'd0, t);
    send(2'b11, 128'd0, t);
    send(2'b11, {96'd0, ty, 16'd0}, t);
  endtask

  function automatic logic [127:0] wr_pl(input logic [31:0] a, input logic [31:0] d);
    return {48'd0, d, a, 16'd0};
  endfunction

  task automatic clear();
    wr_q.delete(); wr_t.delete(); rd_q.delete(); rd_t.delete();
    pk_q.delete(); pk_t.delete(); rs_q.delete(); rs_t.delete();
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_sel"}, 134'(bus.sel), 134'd0);
    chk({pfx, "_err"}, 134'(bus.err_cnt), 134'd0);
    chk({pfx, "_strobes"}, 134'({bus.mem_wren, bus.mem_rden, bus.pkt_out_valid, bus.resp_valid}), 134'd0);
    chk({pfx, "_addr"}, 134'(bus.mem_addr), 134'd0);
    chk({pfx, "_wdata"}, 134'(bus.mem_wdata), 134'd0);
    chk({pfx, "_pkt_out"}, bus.pkt_out, 134'd0);
    chk({pfx, "_resp_data"}, bus.resp_data, 134'd0);
  endtask

  initial begin
    int t, t3, tt;
    int at[5];
    logic [1:0]   ftag[5];
    logic [127:0] fpl[5];
    bus.data_in_valid = 1'b0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("init");
    rst = 1'b0;
    gap(2);

    // sel configuration packet
    ctrl_hdr(16'h9001);
    chk("sel_before", 134'(bus.sel), 134'd0);
    send(2'b11, 128'd1 << 16, t3);
    chk("sel_set", 134'(bus.sel), 134'd1);
    send(2'b10, 128'd0, t);
    gap(3);
    chk("sel_hold", 134'(bus.sel), 134'd1);
    chk("sel_no_mem", 134'(wr_q.size() + rd_q.size()), 134'd0);

    // 4096-word write burst, tail carries the last word
    clear();
    ctrl_hdr(16'h9003);
    for (int i = 0; i < 4096; i++) begin
      send((i == 4095) ? 2'b10 : 2'b11, wr_pl(32'(i), 32'hA500_0000 + 32'(i)), t);
      if (i == 0) t3 = t;
    end
    gap(3);
    chk("wr_count", 134'(wr_q.size()), 134'd4096);
    chk("wr_latency", 134'((wr_t.size() > 0) ? wr_t[0] : -1), 134'(t3));
    for (int i = 0; i < wr_q.size() && i < 4096; i++)
      chk("wr_word", 134'(wr_q[i]), 134'({12'(i), 32'hA500_0000 + 32'(i)}));
    chk("wr_sel", 134'(bus.sel), 134'd1);
    chk("wr_no_rd", 134'(rd_q.size()), 134'd0);

    // read with tail after flit 3
    clear();
    ctrl_hdr(16'h9004);
    send(2'b11, wr_pl(32'd128, 32'd0), t3);
    send(2'b11, 128'd0, t);
    send(2'b10, 128'd0, tt);
    gap(6);
    chk("rd_count", 134'(rd_q.size()), 134'd1);
    chk("rd_addr", 134'((rd_q.size() > 0) ? rd_q[0] : 12'hFFF), 134'd128);
    chk("rd_latency", 134'((rd_t.size() > 0) ? rd_t[0] : -1), 134'(t3));
    chk("resp_count", 134'(rs_q.size()), 134'd3);
    if (rs_q.size() == 3) begin
      chk("resp_head", rs_q[0], {2'b01, 4'h0, 128'd0});
      chk("resp_body", rs_q[1], {2'b11, 4'h0, 96'd0, 16'h9005, 16'd0});
      chk("resp_tail", rs_q[2], {2'b10, 4'hF, 48'd0, 32'h1234_5678, 32'd128, 16'd0});
      chk("resp_start", 134'(rs_t[0]), 134'(tt));
      chk("resp_end", 134'(rs_t[2]), 134'(tt + 2));
    end
    chk("rd_no_wr", 134'(wr_q.size()), 134'd0);

    // read where flit 3 is the tail, address truncated to 12 bits
    clear();
    ctrl_hdr(16'h9004);
    send(2'b10, wr_pl(32'h0001_2345, 32'd0), t3);
    gap(6);
    chk("rd3_addr", 134'((rd_q.size() > 0) ? rd_q[0] : 12'hFFF), 134'h345);
    chk("rd3_resp_count", 134'(rs_q.size()), 134'd3);
    if (rs_q.size() == 3) begin
      chk("rd3_resp_start", 134'(rs_t[0]), 134'(t3 + 1));
      chk("rd3_resp_tail", rs_q[2], {2'b10, 4'hF, 48'd0, 32'h1234_5678, 32'h345, 16'd0});
    end

    // data packet forwarding from the head on
    clear();
    ftag = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    fpl[0] = {96'hCAFE, 16'h9010, 16'h0001};
    for (int k = 1; k < 5; k++) fpl[k] = 128'hB000 + 128'(k);
    for (int k = 0; k < 5; k++) send(ftag[k], fpl[k], at[k]);
    gap(3);
    chk("fwd_count", 134'(pk_q.size()), 134'd5);
    for (int k = 0; k < 5 && k < pk_q.size(); k++) begin
      chk("fwd_flit", pk_q[k], {ftag[k], 4'hF, fpl[k]});
      chk("fwd_latency", 134'(pk_t[k]), 134'(at[k]));
    end
    chk("fwd_no_mem", 134'(wr_q.size() + rd_q.size() + rs_q.size()), 134'd0);
    chk("fwd_sel", 134'(bus.sel), 134'd1);

    // malformed packets
    clear();
    ctrl_hdr(16'h9002);
    send(2'b11, wr_pl(32'd5, 32'd5), t);
    send(2'b10, 128'd0, t);
    chk("err_type", 134'(bus.err_cnt), 134'd1);
    send(2'b01, 128'd0, t);
    send(2'b11, 128'd0, t);
    send(2'b01, 128'd0, t);
    chk("err_head", 134'(bus.err_cnt), 134'd2);
    send(2'b11, 128'd0, t);
    send(2'b11, {96'd0, 16'h9001, 16'd0}, t);
    send(2'b11, 128'd0, t);
    send(2'b10, 128'd0, t);
    gap(2);
    chk("err_restart_sel", 134'(bus.sel), 134'd0);
    chk("err_after_restart", 134'(bus.err_cnt), 134'd2);
    send(2'b11, 128'd1 << 16, t);
    send(2'b10, 128'd1 << 16, t);
    chk("idle_ignore", 134'({bus.err_cnt, bus.sel}), 134'({16'd2, 1'b0}));
    send(2'b01, 128'd0, t);
    send(2'b11, 128'd0, t);
    send(2'b10, {96'd0, 16'h9001, 16'd0}, t);
    chk("err_short", 134'(bus.err_cnt), 134'd3);
    ctrl_hdr(16'h9001);
    send(2'b10, 128'd1 << 16, t);
    gap(1);
    chk("sel_flit3_tail", 134'({bus.err_cnt, bus.sel}), 134'({16'd3, 1'b1}));
    chk("err_no_wr", 134'(wr_q.size()), 134'd0);

    // reset in the middle of a write packet
    clear();
    ctrl_hdr(16'h9003);
    send(2'b11, wr_pl(32'd10, 32'h11), t);
    send(2'b11, wr_pl(32'd11, 32'h22), t);
    gap(1);
    bus.data_in_valid = 1'b1;
    bus.data_in = {2'b11, 4'hF, wr_pl(32'd12, 32'h33)};
    rst = 1'b1;
    #1;
    chk_reset("mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.data_in_valid = 1'b0;
    send(2'b11, wr_pl(32'd13, 32'h44), t);
    send(2'b10, wr_pl(32'd14, 32'h55), t);
    gap(2);
    chk("rst_kept_writes", 134'(wr_q.size()), 134'd2);
    if (wr_q.size() >= 2) chk("rst_w1", 134'(wr_q[1]), 134'({12'd11, 32'h22}));
    chk("rst_err", 134'(bus.err_cnt), 134'd0);
    ctrl_hdr(16'h9003);
    send(2'b11, wr_pl(32'd20, 32'h66), t);
    send(2'b10, wr_pl(32'd21, 32'h77), t);
    gap(3);
    chk("post_rst_count", 134'(wr_q.size()), 134'd4);
    if (wr_q.size() == 4) begin
      chk("post_rst_w0", 134'(wr_q[2]), 134'({12'd20, 32'h66}));
      chk("post_rst_w1", 134'(wr_q[3]), 134'({12'd21, 32'h77}));
    end
    chk("no_wr_rd_overlap", 134'(both), 134'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fast_conf_parser.md
# fast_conf_parser

Consumes the 134-bit FAST flit stream produced by the configuration packet generator and decodes it. Control packets drive the CPU TCM write port and the `sel` run/configure bit, and trigger TCM reads that return a response packet. Data packets pass to the CPU packet path. It sits directly between the FAST packet source and the RV32I core's ITCM/DTCM and packet interfaces.

## Interface
- ADDR_W, 12: TCM word-address width; address fields are truncated to the low ADDR_W bits.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- data_in_valid  in  1  flit valid; there is no backpressure, so every valid flit is consumed.
- data_in  in  134  flit: [133:132] tag (01 head, 10 tail, 11/00 body), [131:128] byte-valid, [127:0] payload.
- mem_wren  out  1  TCM write strobe, one cycle per word.
- mem_addr  out  ADDR_W  TCM word address (write or read).
- mem_wdata  out  32  TCM write data.
- mem_rden  out  1  TCM read strobe; mem_rdata is valid exactly 1 cycle later.
- mem_rdata  in  32  TCM read data.
- sel  out  1  1 = CPU runs, 0 = CPU held for configuration.
- pkt_out_valid  out  1  forwarded data-packet flit valid.
- pkt_out  out  134  forwarded flit, unmodified.
- resp_valid  out  1  read-response flit valid.
- resp_data  out  134  read-response flit.
- err_cnt  out  16  count of malformed or unknown packets; saturates at 16'hFFFF.

## Operation
- Flit index: head = 0, incremented on each valid flit. The type field is payload [31:16] of flit 2. The argument flit is flit 3.
- Exception: if the head flit has [31:16] == 16'h9010, the packet is a data packet and is forwarded starting from the head itself.
- Parse FSM states: IDLE, HDR1, TYPE, SEL, WR, RD, FWD, DROP.
  - IDLE: head tag 01 → HDR1, or FWD if the head is 9010.
  - HDR1 → TYPE on the next flit.
  - TYPE decodes the type: 9001 → SEL, 9003 → WR, 9004 → RD. Any other value → DROP and err_cnt+1.
- SEL: flit 3 bit 16 loads sel. The remaining flits are ignored until the tail.
- WR: every flit from index 3 through the tail inclusive performs one write.
  - mem_addr = payload [47:16], truncated to ADDR_W.
  - mem_wdata = payload [79:48].
  - mem_wren is high 1 cycle after the flit is accepted.
- RD: flit 3 issues mem_rden with addr [47:16] and latches the address. mem_rdata is captured on the following cycle. The response is sent after the tail.
- FWD: every flit is copied to pkt_out 1 cycle after acceptance, through and including the tail.
- Tag 10 in any state → IDLE once that flit's action is done.
- Packets with fewer than 4 flits (tail arrives before flit 3) in SEL/WR/RD have no effect and increment err_cnt.
- Head tag 01 arriving mid-packet: abort the current packet (completed writes stay), err_cnt+1, and restart at HDR1.
- Body or tail flits seen in IDLE are ignored.
- Response FSM states: R_IDLE, R_HEAD, R_BODY, R_TAIL, one flit per cycle with no gaps.
  - R_HEAD: {01, 4'h0, 128'd0}.
  - R_BODY: {11, 4'h0, 96'd0, 16'h9005, 16'd0}.
  - R_TAIL: {10, 4'hF, 48'd0, rdata, 32'(addr), 16'd0}.

## Timing
- Reset values:
  - FSMs in IDLE / R_IDLE.
  - sel = 0, err_cnt = 0.
  - All valid and strobe outputs 0.
  - mem_addr, mem_wdata, pkt_out, resp_data = 0.
- Reset mid-packet: the packet is discarded and the next flit is treated from IDLE. A packet that was partially written is not rolled back.
- Latency:
  - Write strobe: 1 cycle after flit acceptance.
  - Forward: 1 cycle after flit acceptance.
  - Read response head: 1 cycle after the tail is accepted, or 2 cycles after flit 3 if flit 3 is the tail.
- A read response (3 cycles) always completes before the next read's flit 3 can arrive (earliest tail+4). The response path has no queue, and none is needed.
- Valid gaps (data_in_valid = 0) between flits are allowed anywhere: the FSM holds state and strobes stay low.
- sel changes only on the flit-3 cycle of a 9001 packet. It holds across all other packets.
- mem_wren and mem_rden are never high in the same cycle.

## Test plan
- Reset, then send a 9001 packet with flit 3 = 112'd1 << 16 → sel = 1 one cycle after flit 3; no mem_wren.
- 9003 packet with 4096 argument flits, addr 0..4095, data 32'hA5000000+addr → 4096 writes in order, addr/data match, tail included; sel unchanged.
- 9004 packet with flit 3 addr = 128 and mem_rdata model returning 32'h1234_5678 → mem_rden at 128, then resp flits 01 / 9005 / 10, with the tail carrying 32'h12345678 at [79:48] and 128 at [47:16].
- Head [31:16] = 9010 plus 4 body flits (tags 00/00/00/10, 4'hF) → 5 identical flits on pkt_out, each 1 cycle delayed; no mem or sel activity.
- Type 16'h9002 packet, then a head injected at flit 2 of a 9003 packet → err_cnt = 2, no writes, next valid 9001 packet still sets sel.
- Assert rst during flit 5 of a 9003 packet → outputs return to reset values; subsequent body flits ignored; next 9003 packet writes normally.
